// File: rtl/keypad_if.sv
// Keypad entry bundle: raw keypad and control in, BCD digit, load strobe and entry status out.
interface keypad_if;
    logic [9:0] keypad;
    logic       en;
    logic       entry_clr;
    logic [3:0] data;
    logic       loadn;
    logic [1:0] digit_count;
    logic       full;
    logic       key_err;

    modport master (
        output keypad, en, entry_clr,
        input  data, loadn, digit_count, full, key_err
    );

    modport slave (
        input  keypad, en, entry_clr,
        output data, loadn, digit_count, full, key_err
    );
endinterface

// File: rtl/keypad_entry.sv
// Keypad front end: synchronise a one-hot keypad, encode each accepted press to BCD and strobe loadn once.
// Define KEYPAD_DEBOUNCE_EN to require a press to stay stable for DEBOUNCE_CYCLES before it is accepted.
module keypad_entry #(
    parameter int MAX_DIGITS      = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic    clock,
    input  logic    clearn,
    keypad_if.slave kp
);

    if (MAX_DIGITS < 1 || MAX_DIGITS > 3) begin : g_bad_max_digits
        $error("keypad_entry: MAX_DIGITS must be 1..3");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("keypad_entry: DEBOUNCE_CYCLES must be >= 2");
    end

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_LOAD     = 2'd2;
    localparam logic [1:0] S_WAIT     = 2'd3;
    localparam logic [1:0] MAX_CNT    = 2'(MAX_DIGITS);

    logic [9:0] sync1_q, ks_q;
    logic [1:0] state_q, state_d;
    logic [9:0] cap_q, cap_d;
    logic [3:0] data_q, data_d;
    logic       loadn_q, loadn_d;
    logic [1:0] count_q, count_d;
    logic       full_q, full_d;
    logic       key_err_q, key_err_d;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    logic [CNT_W-1:0] dbc_q, dbc_d;
`endif

    function automatic logic is_onehot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    function automatic logic [3:0] encode(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        data_d    = data_q;
        loadn_d   = 1'b1;
        count_d   = count_q;
        key_err_d = 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
        dbc_d     = dbc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ks_q != 10'd0) begin
                    if (!is_onehot(ks_q)) begin
                        key_err_d = 1'b1;
                        state_d   = S_WAIT;
                    end else if (kp.en && !full_q) begin
                        cap_d   = ks_q;
`ifdef KEYPAD_DEBOUNCE_EN
                        dbc_d   = '0;
                        state_d = S_DEBOUNCE;
`else
                        state_d = S_LOAD;
`endif
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_DEBOUNCE: begin
`ifdef KEYPAD_DEBOUNCE_EN
                if (ks_q != cap_q || !kp.en) begin
                    dbc_d   = '0;
                    state_d = S_WAIT;
                end else if (dbc_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    dbc_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    dbc_d   = dbc_q + 1'b1;
                end
`else
                state_d = S_WAIT;
`endif
            end
            S_LOAD: begin
                loadn_d = 1'b0;
                data_d  = encode(cap_q);
                if (count_q != MAX_CNT) count_d = count_q + 2'd1;
                state_d = S_WAIT;
            end
            default: begin
                if (ks_q == 10'd0) state_d = S_IDLE;
            end
        endcase

        // Clearing the entry also cancels a strobe that would have fired this cycle.
        if (kp.entry_clr) begin
            count_d   = 2'd0;
            loadn_d   = 1'b1;
            data_d    = data_q;
            key_err_d = 1'b0;
            state_d   = S_WAIT;
`ifdef KEYPAD_DEBOUNCE_EN
            dbc_d     = '0;
`endif
        end
        full_d = (count_d == MAX_CNT);
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            sync1_q   <= '0;
            ks_q      <= '0;
            state_q   <= S_IDLE;
            cap_q     <= '0;
            data_q    <= '0;
            loadn_q   <= 1'b1;
            count_q   <= '0;
            full_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            sync1_q   <= kp.keypad;
            ks_q      <= sync1_q;
            state_q   <= state_d;
            cap_q     <= cap_d;
            data_q    <= data_d;
            loadn_q   <= loadn_d;
            count_q   <= count_d;
            full_q    <= full_d;
            key_err_q <= key_err_d;
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) dbc_q <= '0;
        else         dbc_q <= dbc_d;
    end
`endif

    assign kp.data        = data_q;
    assign kp.loadn       = loadn_q;
    assign kp.digit_count = count_q;
    assign kp.full        = full_q;
    assign kp.key_err     = key_err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed entry scenarios plus randomized presses against a press-level model.
module tb_keypad_entry;

    localparam int MAXD = 3;
    localparam int DBC  = 16;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int EXTRA    = DBC;
    localparam int MIN_HOLD = DBC + 1;
`else
    localparam int EXTRA    = 0;
    localparam int MIN_HOLD = 1;
`endif

    logic clock = 1'b0;
    logic clearn = 1'b0;
    keypad_if kif();

    keypad_entry #(.MAX_DIGITS(MAXD), .DEBOUNCE_CYCLES(DBC)) dut (
        .clock  (clock),
        .clearn (clearn),
        .kp     (kif)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;

    // Pulse monitor on the falling edge.
    int strobes = 0, low_cycles = 0, errs = 0, err_cycles = 0;
    logic prev_loadn = 1'b1, prev_err = 1'b0;
    logic [3:0] strobe_data = 4'd0;
    always @(negedge clock) begin
        prev_loadn <= kif.loadn;
        prev_err   <= kif.key_err;
        if (kif.loadn === 1'b0) begin
            low_cycles  <= low_cycles + 1;
            strobe_data <= kif.data;
            if (prev_loadn === 1'b1) strobes <= strobes + 1;
        end
        if (kif.key_err === 1'b1) begin
            err_cycles <= err_cycles + 1;
            if (prev_err === 1'b0) errs <= errs + 1;
        end
    end

    // Reference model: press-level rules only.
    int   m_count = 0;
    int   m_data  = 0;
    logic m_en    = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".data"},  32'(kif.data),        32'(m_data));
        chk({tag, ".count"}, 32'(kif.digit_count), 32'(m_count));
        chk({tag, ".full"},  32'(kif.full),        32'(m_count == MAXD));
    endtask

    task automatic press(input logic [9:0] v, input int hold, input string tag);
        int s0, l0, e0, ec0;
        bit acc, err;
        s0 = strobes; l0 = low_cycles; e0 = errs; ec0 = err_cycles;
        kif.keypad = v;
        repeat (hold) @(posedge clock);
        #1 kif.keypad = 10'd0;
        repeat (8) @(posedge clock);
        #1;
        err = ($countones(v) > 1);
        acc = ($countones(v) == 1) && m_en && (m_count < MAXD) && (hold >= MIN_HOLD);
        if (acc) begin
            m_count++;
            m_data = $clog2(v);
        end
        chk({tag, ".strobes"},   32'(strobes - s0),     32'(acc));
        chk({tag, ".low_cyc"},   32'(low_cycles - l0),  32'(acc));
        chk({tag, ".key_err"},   32'(errs - e0),        32'(err));
        chk({tag, ".err_cyc"},   32'(err_cycles - ec0), 32'(err));
        if (acc) chk({tag, ".strobe_data"}, 32'(strobe_data), 32'(m_data));
        chk_state(tag);
    endtask

    task automatic clear_entry(input string tag);
        kif.entry_clr = 1'b1;
        @(posedge clock);
        #1 kif.entry_clr = 1'b0;
        m_count = 0;
        chk({tag, ".count"}, 32'(kif.digit_count), 32'd0);
        chk({tag, ".full"},  32'(kif.full),        32'd0);
    endtask

    initial begin
        int s0;
        kif.keypad    = 10'h010;
        kif.en        = 1'b1;
        kif.entry_clr = 1'b0;

        // Reset with a key held.
        repeat (4) @(posedge clock);
        #1;
        chk("rst.loadn",   32'(kif.loadn),       32'd1);
        chk("rst.data",    32'(kif.data),        32'd0);
        chk("rst.count",   32'(kif.digit_count), 32'd0);
        chk("rst.full",    32'(kif.full),        32'd0);
        chk("rst.key_err", 32'(kif.key_err),     32'd0);
        chk("rst.strobes", 32'(strobes),         32'd0);
        kif.keypad = 10'd0;
        clearn = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // First press with exact latency and one-cycle strobe.
        s0 = strobes;
        kif.keypad = 10'h020;
        repeat (3 + EXTRA) @(posedge clock);
        #1 chk("lat.before", 32'(kif.loadn), 32'd1);
        @(posedge clock);
        #1 chk("lat.low",  32'(kif.loadn), 32'd0);
        chk("lat.data",    32'(kif.data),  32'd5);
        @(posedge clock);
        #1 chk("lat.after", 32'(kif.loadn), 32'd1);
        chk("lat.data_hold", 32'(kif.data), 32'd5);
        kif.keypad = 10'd0;
        repeat (8) @(posedge clock);
        #1;
        m_count = 1; m_data = 5;
        chk("lat.strobes", 32'(strobes - s0), 32'd1);
        chk_state("lat");

        press(10'h008, 4 + EXTRA, "key3");
        press(10'h001, 4 + EXTRA, "key0");
        press(10'h080, 4 + EXTRA, "full_key7");
        clear_entry("clr1");
        m_en = 1'b0; kif.en = 1'b0;
        press(10'h010, 4 + EXTRA, "dis_key4");
        m_en = 1'b1; kif.en = 1'b1;
        press(10'h006, 4 + EXTRA, "multi");
        press(10'h002, 4 + EXTRA, "key1");
        press(10'h200, 200, "hold9");

        // entry_clr lands on the LOAD cycle.
        s0 = strobes;
        kif.keypad = 10'h200;
        repeat (3 + EXTRA) @(posedge clock);
        #1 kif.entry_clr = 1'b1;
        @(posedge clock);
        #1 kif.entry_clr = 1'b0;
        repeat (3) @(posedge clock);
        #1 kif.keypad = 10'd0;
        repeat (8) @(posedge clock);
        #1;
        m_count = 0;
        chk("collide.strobes", 32'(strobes - s0), 32'd0);
        chk_state("collide");

`ifdef KEYPAD_DEBOUNCE_EN
        s0 = strobes;
        for (int i = 0; i < 8; i++) begin
            kif.keypad = (i % 2 == 0) ? 10'h100 : 10'h000;
            repeat (5) @(posedge clock);
            #1;
        end
        kif.keypad = 10'd0;
        repeat (8) @(posedge clock);
        #1 chk("bounce.strobes", 32'(strobes - s0), 32'd0);
        press(10'h100, DBC + 4, "stable8");
`endif

        // Randomized presses, enables and clears.
        for (int it = 0; it < 40; it++) begin
            logic [9:0] v;
            int hold, a, b;
            if ($urandom_range(0, 7) == 0) clear_entry("rnd.clr");
            if ($urandom_range(0, 5) == 0) begin
                m_en = ~m_en;
                kif.en = m_en;
            end
            a = $urandom_range(0, 9);
            b = (a + $urandom_range(1, 9)) % 10;
            v = 10'd1 << a;
            if ($urandom_range(0, 4) == 0) v = v | (10'd1 << b);
`ifdef KEYPAD_DEBOUNCE_EN
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DBC - 2) : $urandom_range(DBC + 3, DBC + 10);
`else
            hold = $urandom_range(1, 12);
`endif
            press(v, hold, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
